// File: rtl/row_matrix_scanner.sv
// Scans an 8x8 playfield array onto one-hot row drivers with a blanking gap
// between rows. Optional display blinking is enabled by defining BLINK_EN.
module row_matrix_scanner #(
   parameter int DWELL_CYCLES   = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter int BLINK_DIV_LOG2 = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       clr,
`ifdef BLINK_EN
   input  logic       blink,
`endif
   output logic [7:0] row_sel,
   output logic [7:0] col_data,
   output logic [2:0] scan_row,
   output logic       frame_start
);

   localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   // With no blank gap, BLANK is only visited once, straight after reset.
   localparam logic [CNT_W-1:0] BLANK_LAST =
      (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

   if (DWELL_CYCLES < 1 || BLANK_CYCLES < 0 || BLINK_DIV_LOG2 < 1) begin : g_bad_param
      $error("row_matrix_scanner: illegal parameter value");
   end

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       scan_row_q, scan_row_d;
   logic [7:0]       shadow_q, shadow_d;
   logic [7:0]       array_q [8];
   logic [7:0]       array_d [8];
   logic [2:0]       next_row;
   logic             drive;
   logic             blink_mask;

   // Playfield array: clear wins over a same-cycle row write.
   always_comb begin
      array_d = array_q;
      if (clr) begin
         for (int i = 0; i < 8; i++) begin
            array_d[i] = 8'h00;
         end
      end else if (wr_en) begin
         array_d[wr_row] = wr_data;
      end
   end

   // Scan FSM. The shadow register is loaded on the edge that enters DRIVE
   // from the array as it stood before that edge, so the driven row never tears.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      scan_row_d = scan_row_q;
      shadow_d   = shadow_q;
      next_row   = scan_row_q + 3'd1;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d  = ST_DRIVE;
               cnt_d    = '0;
               shadow_d = array_q[scan_row_q];
            end
         end
         ST_DRIVE: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d      = '0;
               scan_row_d = next_row;
               if (BLANK_CYCLES == 0) begin
                  state_d  = ST_DRIVE;
                  shadow_d = array_q[next_row];
               end else begin
                  state_d  = ST_BLANK;
               end
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BLANK;
         cnt_q      <= '0;
         scan_row_q <= 3'd0;
         shadow_q   <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            array_q[i] <= 8'h00;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scan_row_q <= scan_row_d;
         shadow_q   <= shadow_d;
         array_q    <= array_d;
      end
   end

`ifdef BLINK_EN
   logic [BLINK_DIV_LOG2-1:0] blink_cnt_q, blink_cnt_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + BLINK_DIV_LOG2'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q <= '0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
      end
   end

   // Blinking only darkens the columns; row timing is left untouched.
   assign blink_mask = blink & blink_cnt_q[BLINK_DIV_LOG2-1];
`else
   assign blink_mask = 1'b0;
`endif

   assign drive       = (state_q == ST_DRIVE);
   assign row_sel     = drive ? (8'd1 << scan_row_q) : 8'd0;
   assign col_data    = (drive && !blink_mask) ? shadow_q : 8'd0;
   assign scan_row    = scan_row_q;
   assign frame_start = drive && (cnt_q == '0) && (scan_row_q == 3'd0);

   a_row_sel_onehot0 : assert property (@(posedge clk) disable iff (reset)
      $onehot0(row_sel));
   a_dark_when_blank : assert property (@(posedge clk) disable iff (reset)
      (row_sel == 8'h00) |-> (col_data == 8'h00));

endmodule

// File: tb/tb_row_matrix_scanner.sv
// Directed bench for row_matrix_scanner with DWELL=4, BLANK=2; the blink
// checks are compiled in only when BLINK_EN is defined.
module tb_row_matrix_scanner;

   localparam int DWELL = 4;
   localparam int BLANK = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       clr;
   logic [7:0] row_sel;
   logic [7:0] col_data;
   logic [2:0] scan_row;
   logic       frame_start;
`ifdef BLINK_EN
   logic       blink;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic       wr_en;
      logic [2:0] wr_row;
      logic [7:0] wr_data;
      logic [7:0] exp_row_sel;
      logic [7:0] exp_col;
      logic [2:0] exp_scan;
      logic       exp_fs;
   } vec_t;

   vec_t vecs[$];

   row_matrix_scanner #(
      .DWELL_CYCLES  (DWELL),
      .BLANK_CYCLES  (BLANK),
      .BLINK_DIV_LOG2(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_data    (wr_data),
      .clr        (clr),
`ifdef BLINK_EN
      .blink      (blink),
`endif
      .row_sel    (row_sel),
      .col_data   (col_data),
      .scan_row   (scan_row),
      .frame_start(frame_start)
   );

   // ---- clock / watchdog ----
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---- driver tasks ----
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      wr_en = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic write_row(input logic [2:0] r, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_row  = r;
      wr_data = d;
      tick();
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %02h, expected %02h", name, cyc, got, exp);
      end
   endtask

   task automatic wait_row(input int r);
      int n = 0;
      logic [7:0] want;
      want = 8'd1 << r;
      while (row_sel !== want && n < 100) begin
         tick();
         n++;
      end
      check($sformatf("wait_row%0d", r), row_sel, want);
   endtask

   task automatic wait_frame();
      int n = 0;
      while (frame_start !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("wait_frame", {7'b0, frame_start}, 8'h01);
   endtask

   function automatic void add_vec(input int c, input logic we, input logic [2:0] wr,
                                   input logic [7:0] wd, input logic [7:0] rs,
                                   input logic [7:0] cd, input logic [2:0] sr,
                                   input logic fs);
      vec_t v;
      v.cyc = c; v.wr_en = we; v.wr_row = wr; v.wr_data = wd;
      v.exp_row_sel = rs; v.exp_col = cd; v.exp_scan = sr; v.exp_fs = fs;
      vecs.push_back(v);
   endfunction

   // ---- stimulus and checking ----
   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00; clr = 1'b0;
`ifdef BLINK_EN
      blink = 1'b0;
`endif
      //      cyc we row data  row_sel col  scan fs
      add_vec(  0, 1, 3, 8'hE0, 8'h00, 8'h00, 0, 0);
      add_vec(  1, 1, 7, 8'hFF, 8'h00, 8'h00, 0, 0);
      add_vec(  2, 1, 2, 8'h38, 8'h01, 8'h00, 0, 1);
      add_vec(  3, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);
      add_vec(  5, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);
      add_vec(  6, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0);
      add_vec(  7, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0);
      add_vec(  8, 0, 0, 8'h00, 8'h02, 8'h00, 1, 0);
      add_vec( 11, 0, 0, 8'h00, 8'h02, 8'h00, 1, 0);
      add_vec( 12, 0, 0, 8'h00, 8'h00, 8'h00, 2, 0);
      add_vec( 14, 0, 0, 8'h00, 8'h04, 8'h38, 2, 0);
      add_vec( 15, 1, 2, 8'h1C, 8'h04, 8'h38, 2, 0);
      add_vec( 16, 0, 0, 8'h00, 8'h04, 8'h38, 2, 0);
      add_vec( 17, 0, 0, 8'h00, 8'h04, 8'h38, 2, 0);
      add_vec( 18, 0, 0, 8'h00, 8'h00, 8'h00, 3, 0);
      add_vec( 20, 0, 0, 8'h00, 8'h08, 8'hE0, 3, 0);
      add_vec( 23, 0, 0, 8'h00, 8'h08, 8'hE0, 3, 0);
      add_vec( 26, 0, 0, 8'h00, 8'h10, 8'h00, 4, 0);
      add_vec( 44, 0, 0, 8'h00, 8'h80, 8'hFF, 7, 0);
      add_vec( 47, 0, 0, 8'h00, 8'h80, 8'hFF, 7, 0);
      add_vec( 48, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      add_vec( 49, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      add_vec( 50, 0, 0, 8'h00, 8'h01, 8'h00, 0, 1);
      add_vec( 51, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);
      add_vec( 54, 1, 1, 8'h0F, 8'h00, 8'h00, 1, 0);
      add_vec( 56, 0, 0, 8'h00, 8'h02, 8'h0F, 1, 0);
      add_vec( 59, 0, 0, 8'h00, 8'h02, 8'h0F, 1, 0);
      add_vec( 62, 0, 0, 8'h00, 8'h04, 8'h1C, 2, 0);
      // Write in row 3's latch cycle: not captured until the following frame.
      add_vec( 67, 1, 3, 8'h55, 8'h00, 8'h00, 3, 0);
      add_vec( 68, 0, 0, 8'h00, 8'h08, 8'hE0, 3, 0);
      add_vec(116, 0, 0, 8'h00, 8'h08, 8'h55, 3, 0);

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;

      foreach (vecs[i]) begin
         while (cyc < vecs[i].cyc) tick();
         wr_en   = vecs[i].wr_en;
         wr_row  = vecs[i].wr_row;
         wr_data = vecs[i].wr_data;
         check("row_sel", row_sel, vecs[i].exp_row_sel);
         check("col_data", col_data, vecs[i].exp_col);
         check("scan_row", {5'b0, scan_row}, {5'b0, vecs[i].exp_scan});
         check("frame_start", {7'b0, frame_start}, {7'b0, vecs[i].exp_fs});
      end
      tick();

      // clr together with a row 0 write: clear wins, every row reads back 0.
      clr = 1'b1; wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hAA;
      tick();
      wait_frame();
      for (int r = 0; r < 8; r++) begin
         wait_row(r);
         check($sformatf("clr_row%0d", r), col_data, 8'h00);
      end

      // Reset in the middle of row 5's drive.
      write_row(3'd5, 8'h5A);
      write_row(3'd0, 8'h81);
      wait_row(0);
      check("pre_reset_row0", col_data, 8'h81);
      wait_row(5);
      check("pre_reset_row5", col_data, 8'h5A);
      tick();
      reset = 1'b1;
      tick();
      check("rst_row_sel", row_sel, 8'h00);
      check("rst_col_data", col_data, 8'h00);
      check("rst_scan_row", {5'b0, scan_row}, 8'h00);
      check("rst_frame_start", {7'b0, frame_start}, 8'h00);
      reset = 1'b0;
      cyc   = 0;
      tick();
      check("rst_c1_row_sel", row_sel, 8'h00);
      tick();
      check("rst_c2_row_sel", row_sel, 8'h01);
      check("rst_c2_frame_start", {7'b0, frame_start}, 8'h01);
      check("rst_c2_col_data", col_data, 8'h00);
      wait_row(5);
      check("rst_row5_cleared", col_data, 8'h00);

`ifdef BLINK_EN
      for (int r = 0; r < 8; r++) write_row(3'(r), 8'hFF);
      wait_frame();
      blink = 1'b1;
      repeat (48) begin
         if (row_sel != 8'h00)
            check("blink_on", col_data, ((cyc % 16) >= 8) ? 8'h00 : 8'hFF);
         tick();
      end
      blink = 1'b0;
      repeat (48) begin
         if (row_sel != 8'h00)
            check("blink_off", col_data, 8'hFF);
         tick();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
